// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: credit-limited FIFO reader that frames words into fixed-length bursts,
// padding a burst to completion when the FIFO starves for too long.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  m_pad,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST  = BW'(BURST_LEN - 1);
  localparam logic [SW-1:0] LIMIT = SW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
  logic [1:0]            r_occ, w_level, w_base;
  logic                  r_infl, r_underrun;
  logic                  w_hs, w_rpop, w_starve, w_timeout, w_sop, w_eop;
  logic [BW-1:0]         r_beat;
  logic [SW-1:0]         r_starve;
  logic [CNT_WIDTH-1:0]  r_words;

  always_ff @(posedge rd_clk)
    r_state <= rd_rst ? IDLE : w_next;

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_hs && w_sop) w_next = STREAM;
    else if (r_state != IDLE && w_hs && w_eop) w_next = IDLE;
    else if (w_timeout) w_next = PAD;
  end

  always_comb begin
    m_pad      = r_state == PAD;
    m_valid    = m_pad || (r_occ != 2'd0);
    m_data     = m_pad ? '0 : r_buf0;
    w_sop      = r_beat == '0;
    w_eop      = r_beat == LAST;
    m_sop      = m_valid && w_sop;
    m_eop      = m_valid && w_eop;
    w_hs       = m_valid && m_ready;
    w_rpop     = w_hs && !m_pad;
    w_base     = r_occ - {1'b0, w_rpop};
    w_level    = w_base + {1'b0, r_infl};
    fifo_rd_en = !rd_rst && !fifo_empty && !m_pad && (w_level < 2'd2);
    w_starve   = r_state == STREAM && r_occ == 2'd0 && !r_infl && fifo_empty;
    w_timeout  = w_starve && r_starve == LIMIT;
  end

  assign underrun = r_underrun;
  assign word_cnt = r_words;

  // A read in flight at reset is dropped by clearing r_infl, so its data is never captured.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_occ      <= '0;
      r_infl     <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_beat     <= '0;
      r_starve   <= '0;
      r_underrun <= 1'b0;
      r_words    <= '0;
    end else begin
      r_infl <= fifo_rd_en;
      r_occ  <= w_level;
      if (w_rpop) r_buf0 <= r_buf1;
      if (r_infl && w_base == 2'd0) r_buf0 <= fifo_data;
      else if (r_infl) r_buf1 <= fifo_data;
      if (w_hs) r_beat <= w_eop ? '0 : r_beat + 1'b1;
      r_starve   <= w_starve ? r_starve + 1'b1 : '0;
      r_underrun <= w_timeout;
      if (w_rpop) r_words <= r_words + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed tests of fifo_burst_reader against a simple FIFO model
// with one-cycle read latency.
module tb_fifo_burst_reader;
  localparam int DW = 16, BL = 8, TO = 16, CW = 16;
  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          m_ready = 1'b0;
  logic          force_ne = 1'b0;
  logic          fifo_empty, fifo_rd_en, m_valid, m_sop, m_eop, m_pad, underrun;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_cnt;
  logic [DW-1:0] mem [0:4095];
  int            n_push = 0, n_pop = 0;
  int            total = 0, bad = 0;

  fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop), .m_pad(m_pad), .underrun(underrun), .word_cnt(word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = !force_ne && (n_push == n_pop);

  always @(posedge rd_clk)
    if (fifo_rd_en && n_pop != n_push) begin
      fifo_data <= mem[n_pop];
      n_pop     <= n_pop + 1;
    end

  task push(input logic [DW-1:0] w);
    mem[n_push] = w;
    n_push++;
  endtask

  task do_reset(input int n);
    rd_rst = 1'b1;
    m_ready = 1'b0;
    force_ne = 1'b0;
    repeat (n) @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  task test_reset;
    @(negedge rd_clk);
    rd_rst = 1'b1;
    force_ne = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en cyc %0d: got %b want 0", i, fifo_rd_en); end
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc %0d: got %b want 0", i, m_valid); end
      @(negedge rd_clk);
    end
    rd_rst = 1'b0;
    #1;
    total++;
    if ({m_valid, m_sop, m_eop, m_pad, underrun, m_data, word_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b pad=%b ur=%b data=%0h cnt=%0d want all 0",
               m_valid, m_sop, m_eop, m_pad, underrun, m_data, word_cnt);
    end
    total++;
    if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL reset_first_read: got %b want 1", fifo_rd_en); end
    force_ne = 1'b0;
    @(negedge rd_clk);
  endtask

  task test_stream;
    int k, first_rd, first_v;
    for (int i = 1; i <= 16; i++) push(DW'(i));
    do_reset(2);
    m_ready = 1'b1;
    k = 0; first_rd = -1; first_v = -1;
    for (int cyc = 0; cyc < 60 && k < 16; cyc++) begin
      #1;
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        k++;
        total++;
        if (m_data !== DW'(k) || m_sop !== (k % BL == 1) || m_eop !== (k % BL == 0) || m_pad !== 1'b0) begin
          bad++;
          $display("FAIL stream_word %0d: got data=%0d sop=%b eop=%b pad=%b want data=%0d sop=%b eop=%b pad=0",
                   k, m_data, m_sop, m_eop, m_pad, k, k % BL == 1, k % BL == 0);
        end
        total++;
        if (cyc != first_v + k - 1) begin bad++; $display("FAIL stream_rate word %0d: got cycle %0d want %0d", k, cyc, first_v + k - 1); end
      end
      @(negedge rd_clk);
    end
    #1;
    total++;
    if (k != 16) begin bad++; $display("FAIL stream_count: got %0d want 16", k); end
    total++;
    if (first_v - first_rd != 2) begin bad++; $display("FAIL stream_latency: got %0d want 2", first_v - first_rd); end
    total++;
    if (word_cnt !== CW'(16)) begin bad++; $display("FAIL stream_word_cnt: got %0d want 16", word_cnt); end
    @(negedge rd_clk);
  endtask

  task test_backpressure;
    logic [DW-1:0]   want [0:999];
    logic [DW+3:0]   prev, cur;
    logic            pv, pr;
    int              k, outstanding;
    for (int i = 0; i < 1000; i++) begin
      want[i] = DW'($urandom);
      push(want[i]);
    end
    do_reset(2);
    k = 0; outstanding = 0; pv = 1'b0; pr = 1'b1; prev = '0;
    for (int cyc = 0; cyc < 6000 && k < 1000; cyc++) begin
      m_ready = 1'($urandom_range(0, 1));
      #1;
      cur = {m_valid, m_sop, m_eop, m_pad, m_data};
      if (pv && !pr) begin
        total++;
        if (cur !== prev) begin bad++; $display("FAIL bp_hold cyc %0d: got %0h want %0h", cyc, cur, prev); end
      end
      total++;
      if (outstanding > 2) begin bad++; $display("FAIL bp_credit cyc %0d: got %0d want <=2", cyc, outstanding); end
      if (m_valid && m_ready) begin
        total++;
        if (m_data !== want[k] || m_pad !== 1'b0 || m_sop !== (k % BL == 0) || m_eop !== (k % BL == BL - 1)) begin
          bad++;
          $display("FAIL bp_word %0d: got data=%0h sop=%b eop=%b pad=%b want data=%0h sop=%b eop=%b pad=0",
                   k, m_data, m_sop, m_eop, m_pad, want[k], k % BL == 0, k % BL == BL - 1);
        end
        k++;
        outstanding--;
      end
      if (fifo_rd_en) outstanding++;
      pv = m_valid; pr = m_ready; prev = cur;
      @(negedge rd_clk);
    end
    #1;
    total++;
    if (k != 1000) begin bad++; $display("FAIL bp_count: got %0d want 1000", k); end
    total++;
    if (word_cnt !== CW'(1000)) begin bad++; $display("FAIL bp_word_cnt: got %0d want 1000", word_cnt); end
    @(negedge rd_clk);
  endtask

  task test_underrun;
    int k, last_hs, ur_cnt, ur_cyc, first_pad, npad;
    logic done;
    push(DW'(100)); push(DW'(200)); push(DW'(300));
    do_reset(2);
    m_ready = 1'b1;
    k = 0; last_hs = -1; ur_cnt = 0; ur_cyc = -1; first_pad = -1; npad = 0; done = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      #1;
      if (underrun) begin ur_cnt++; if (ur_cyc < 0) ur_cyc = cyc; end
      if (m_valid && m_pad && first_pad < 0) first_pad = cyc;
      if (m_valid && m_ready) begin
        if (!m_pad) begin
          total++;
          if (m_data !== DW'(100 * (k + 1)) || m_sop !== (k == 0)) begin
            bad++;
            $display("FAIL ur_word %0d: got data=%0d sop=%b want data=%0d sop=%b", k, m_data, m_sop, 100 * (k + 1), k == 0);
          end
          k++;
          last_hs = cyc;
        end else begin
          npad++;
          total++;
          if (m_data !== '0 || m_sop !== 1'b0 || m_eop !== (npad == 5)) begin
            bad++;
            $display("FAIL ur_pad %0d: got data=%0h sop=%b eop=%b want data=0 sop=0 eop=%b", npad, m_data, m_sop, m_eop, npad == 5);
          end
          if (m_eop) done = 1'b1;
        end
      end
      @(negedge rd_clk);
    end
    #1;
    total++;
    if (k != 3) begin bad++; $display("FAIL ur_real_count: got %0d want 3", k); end
    total++;
    if (npad != 5) begin bad++; $display("FAIL ur_pad_count: got %0d want 5", npad); end
    total++;
    if (ur_cnt != 1) begin bad++; $display("FAIL ur_pulses: got %0d want 1", ur_cnt); end
    total++;
    if (ur_cyc != last_hs + TO + 1) begin bad++; $display("FAIL ur_timing: got %0d want %0d", ur_cyc - last_hs, TO + 1); end
    total++;
    if (first_pad != ur_cyc) begin bad++; $display("FAIL ur_first_pad: got cycle %0d want %0d", first_pad, ur_cyc); end
    total++;
    if (word_cnt !== CW'(3)) begin bad++; $display("FAIL ur_word_cnt: got %0d want 3", word_cnt); end
    @(negedge rd_clk);
  endtask

  task test_recovery;
    int   n_new;
    logic pushed, after_eop;
    push(DW'(7)); push(DW'(8));
    do_reset(2);
    n_new = 0; pushed = 1'b0; after_eop = 1'b0;
    for (int cyc = 0; cyc < 150 && n_new < 4; cyc++) begin
      m_ready = (cyc % 3) != 0;
      #1;
      if (m_pad && !pushed) begin
        for (int i = 11; i <= 14; i++) push(DW'(i));
        pushed = 1'b1;
      end
      if (m_pad) begin
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rec_no_read cyc %0d: got %b want 0", cyc, fifo_rd_en); end
      end
      if (after_eop) begin
        total++;
        if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL rec_resume cyc %0d: got %b want 1", cyc, fifo_rd_en); end
        after_eop = 1'b0;
      end
      if (m_valid && m_ready && m_pad && m_eop) after_eop = 1'b1;
      if (m_valid && m_ready && !m_pad && pushed) begin
        total++;
        if (m_data !== DW'(11 + n_new) || m_sop !== (n_new == 0)) begin
          bad++;
          $display("FAIL rec_word %0d: got data=%0d sop=%b want data=%0d sop=%b", n_new, m_data, m_sop, 11 + n_new, n_new == 0);
        end
        n_new++;
      end
      @(negedge rd_clk);
    end
    total++;
    if (n_new != 4) begin bad++; $display("FAIL rec_count: got %0d want 4", n_new); end
  endtask

  task test_mid_reset;
    int k;
    do_reset(2);
    m_ready = 1'b1;
    push(DW'(21)); push(DW'(22)); push(DW'(23));
    #1;
    total++;
    if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL mid_first_read: got %b want 1", fifo_rd_en); end
    @(negedge rd_clk);
    rd_rst = 1'b1;
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rst_read: got %b want 0", fifo_rd_en); end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    #1;
    total++;
    if (word_cnt !== '0 || m_valid !== 1'b0) begin bad++; $display("FAIL mid_after_rst: got cnt=%0d valid=%b want cnt=0 valid=0", word_cnt, m_valid); end
    k = 0;
    for (int cyc = 0; cyc < 30 && k < 2; cyc++) begin
      if (cyc > 0) #1;
      if (m_valid && m_ready) begin
        total++;
        if (m_data !== DW'(22 + k) || m_sop !== (k == 0) || m_pad !== 1'b0) begin
          bad++;
          $display("FAIL mid_word %0d: got data=%0d sop=%b pad=%b want data=%0d sop=%b pad=0", k, m_data, m_sop, m_pad, 22 + k, k == 0);
        end
        k++;
      end
      @(negedge rd_clk);
    end
    #1;
    total++;
    if (k != 2) begin bad++; $display("FAIL mid_count: got %0d want 2", k); end
    total++;
    if (word_cnt !== CW'(2)) begin bad++; $display("FAIL mid_word_cnt: got %0d want 2", word_cnt); end
    @(negedge rd_clk);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_underrun;
    test_recovery;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side consumer of the asynchronous FIFO, clocked entirely in the read domain. Pops words from the FIFO with a credit-limited read request that absorbs the FIFO's one-cycle read latency, buffers them in a 2-entry output buffer, and presents them as a valid/ready stream framed into fixed-length bursts with start/end markers. If the FIFO runs dry mid-burst for too long, it closes the burst with pad words so downstream framing never stalls indefinitely.

## Interface
- DATA_WIDTH, 16, word width; matches the FIFO data width
- BURST_LEN, 8, words per burst; legal range 2..256
- TIMEOUT, 16, starved cycles mid-burst before padding; at least 1
- CNT_WIDTH, 16, width of word_cnt

- rd_clk  in  1  read-domain clock; the single clock of this block
- rd_rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag, rd_clk domain
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after an accepted read
- fifo_rd_en  out  1  FIFO read request
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  output word; 0 during pad
- m_sop  out  1  first word of burst
- m_eop  out  1  last word of burst
- m_pad  out  1  word is padding, not FIFO data
- underrun  out  1  one-cycle pulse on entering PAD
- word_cnt  out  CNT_WIDTH  count of non-pad words delivered

## Operation
- Credit: occ (0..2, buffer entries) + infl (0..1, read issued, data not yet captured) must stay at or below 2.
- fifo_rd_en = !fifo_empty && state != PAD && (occ + infl - pop) < 2, where pop = m_valid && m_ready. Combinational from registered state, fifo_empty and m_ready.
- infl is set the cycle after fifo_rd_en is high. fifo_data is captured into the buffer on the following edge.
- Buffer is FIFO-ordered with 2 entries. The head drives m_data. m_valid = occ != 0 in IDLE/STREAM, and 1 in PAD.
- While m_valid && !m_ready, all m_* outputs hold stable.
- beat_cnt (0..BURST_LEN-1) advances on each handshake and wraps to 0 after the m_eop beat. m_sop = (beat_cnt == 0), m_eop = (beat_cnt == BURST_LEN-1).
- States:
  - IDLE: beat_cnt is 0.
  - IDLE -> STREAM on a sop handshake.
  - STREAM -> IDLE on an eop handshake.
  - STREAM -> PAD when starve_cnt reaches TIMEOUT.
  - PAD -> IDLE on an eop handshake.
- starve_cnt increments each STREAM cycle with occ == 0, infl == 0 and fifo_empty == 1. Any other cycle, or any other state, clears it to 0.
- PAD: m_data = 0, m_pad = 1, no FIFO reads. Emits the remaining beats of the burst up to and including eop.
- underrun pulses for exactly one cycle, the cycle after the STREAM -> PAD decision.
- word_cnt increments on each non-pad handshake and wraps modulo 2^CNT_WIDTH.

## Timing
- Reset values: all outputs 0, state IDLE, occ = infl = beat_cnt = starve_cnt = 0.
- Reset has priority over all other activity. A read in flight at reset is dropped; its returning data is ignored.
- fifo_rd_en is 0 during the cycle rd_rst is high.
- Latency: fifo_rd_en high in cycle N, fifo_data valid in N+1, m_valid high in N+2, with m_ready held high.
- Throughput: 1 word per cycle sustained while FIFO not empty and m_ready = 1.
- Simultaneous capture and pop in one cycle: occ unchanged, order preserved.
- Padding starts TIMEOUT+1 cycles after the last real word left and the FIFO went empty. The first pad word appears with m_valid in the cycle underrun pulses.
- fifo_empty deasserting during PAD has no effect until PAD -> IDLE. Reads resume the next cycle.

## Test plan
- Reset: hold rd_rst 3 cycles with fifo_empty = 0 -> fifo_rd_en = 0 and m_valid = 0 throughout; all outputs 0 in the first cycle after release; fifo_rd_en = 1 in the first post-reset cycle.
- Streaming: FIFO model holding words 1..16, m_ready = 1, BURST_LEN = 8 -> 16 consecutive words in order; m_sop on words 1 and 9; m_eop on words 8 and 16; first m_valid 2 cycles after first fifo_rd_en; word_cnt = 16.
- Backpressure: m_ready toggled randomly, 1000 random words -> no loss, duplication or reordering; occ + infl never exceeds 2; m_* stable while stalled.
- Underrun: 3 words then FIFO empty, TIMEOUT = 16 -> words 1..3 (sop on 1), then after 17 empty cycles underrun pulses once and 5 pad words (m_data = 0, m_pad = 1) end with eop; word_cnt = 3.
- Recovery: FIFO refills during PAD -> no fifo_rd_en until the pad eop handshake; the next real word carries m_sop.
- Mid-operation reset: rd_rst asserted one cycle after fifo_rd_en -> the in-flight word is never output; after release, framing restarts at sop and word_cnt = 0.
